db_arbiter: RTL and testbench

Two-master arbiter for the shared data bus (`db_*`) in front of the MMU/memory port. Master 0 is the CPU core and master 1 is a secondary requester such as DMA or a debug loader. The arbiter grants the bus to one master per transaction using round-robin order, muxes address, data and control from the granted master to the slave, and steers `ready` and abort back to that master only. A watchdog counter aborts transactions the slave never completes.

---
 rtl/db_arbiter_if.sv | 38 +++
 rtl/db_arbiter.sv | 132 +++++++++++++
 tb/tb_db_arbiter.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/db_arbiter_if.sv
// Shared data-bus types and the db_* handshake interface.
// One instance per master port and one for the slave side.
package db_pkg;
  typedef enum logic [1:0] {
    MEM_ACCESS_NONE,
    MEM_ACCESS_READ,
    MEM_ACCESS_WRITE,
    MEM_ACCESS_EXEC
  } mem_access_t;

  typedef enum logic [1:0] {
    MEM_LEN_B,
    MEM_LEN_H,
    MEM_LEN_W
  } mem_len_t;
endpackage

interface db_if;
  import db_pkg::*;

  logic [31:0] addr;
  logic [31:0] dataOut;
  logic [31:0] dataIn;
  mem_access_t accessType;
  mem_len_t    memLen;
  logic        ready;
  logic        abort;

  modport master (
    output addr, dataOut, accessType, memLen,
    input  dataIn, ready, abort
  );

  modport slave (
    input  addr, dataOut, accessType, memLen,
    output dataIn, ready, abort
  );
endinterface

// File: rtl/db_arbiter.sv
// Round-robin two-master arbiter for the shared data bus,
// with a watchdog that aborts transactions the slave never finishes.
module db_arbiter
  import db_pkg::*;
#(
  parameter string       TAG     = "DbArbiter",
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       res,
  db_if.slave        m0,
  db_if.slave        m1,
  db_if.master       s,
  output logic [1:0] grant,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY0,
    BUSY1
  } state_t;

  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      nextState;
  logic        lastGrant;
  logic [15:0] waitCnt;

  logic req0;
  logic req1;
  logic reqCur;
  logic wdFire;
  logic done;

  assign req0 = (m0.accessType != MEM_ACCESS_NONE);
  assign req1 = (m1.accessType != MEM_ACCESS_NONE);

  always_comb begin
    reqCur = 1'b0;
    if (state == BUSY0) reqCur = req0;
    if (state == BUSY1) reqCur = req1;
  end

  // Watchdog only fires on a live request the slave has not answered.
  assign wdFire = WD_EN && reqCur
                && (waitCnt == WD_LAST)
                && !s.ready && !s.abort;

  assign done = !reqCur || s.ready
              || s.abort || wdFire;

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      waitCnt   <= 16'd0;
    end else begin
      state <= nextState;
      if (state == IDLE) begin
        waitCnt <= 16'd0;
        if (nextState == BUSY0) lastGrant <= 1'b0;
        if (nextState == BUSY1) lastGrant <= 1'b1;
      end else begin
        waitCnt <= waitCnt + 16'd1;
      end
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (req0 && (!req1 || lastGrant))
          nextState = BUSY0;
        else if (req1)
          nextState = BUSY1;
      end
      BUSY0, BUSY1: begin
        if (done) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    s.addr       = 32'd0;
    s.dataOut    = 32'd0;
    s.accessType = MEM_ACCESS_NONE;
    s.memLen     = MEM_LEN_W;
    m0.dataIn    = s.dataIn;
    m1.dataIn    = s.dataIn;
    m0.ready     = 1'b0;
    m0.abort     = 1'b0;
    m1.ready     = 1'b0;
    m1.abort     = 1'b0;
    grant        = 2'b00;
    timeout      = wdFire;
    unique case (1'b1)
      (state == BUSY0): begin
        s.addr       = m0.addr;
        s.dataOut    = m0.dataOut;
        s.accessType = m0.accessType;
        s.memLen     = m0.memLen;
        m0.ready     = reqCur && s.ready
                     && !s.abort;
        m0.abort     = reqCur
                     && (s.abort || wdFire);
        grant        = 2'b01;
      end
      (state == BUSY1): begin
        s.addr       = m1.addr;
        s.dataOut    = m1.dataOut;
        s.accessType = m1.accessType;
        s.memLen     = m1.memLen;
        m1.ready     = reqCur && s.ready
                     && !s.abort;
        m1.abort     = reqCur
                     && (s.abort || wdFire);
        grant        = 2'b10;
      end
      default: ;
    endcase
  end

  assert property (@(posedge clk) disable iff (res)
    $onehot0(grant))
    else $error("%s: grant not one-hot", TAG);

endmodule

// File: tb/tb_db_arbiter.sv
// Bench for db_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level round-robin model.
module tb_db_arbiter;
  import db_pkg::*;

  logic       clk = 1'b0;
  logic       res;
  logic [1:0] grant;
  logic       timeout;

  db_if m0b ();
  db_if m1b ();
  db_if sb ();

  always #5 clk = ~clk;

  db_arbiter #(
    .TAG("DbArbiter"),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .res(res),
    .m0(m0b),
    .m1(m1b),
    .s(sb),
    .grant(grant),
    .timeout(timeout)
  );

  int tests = 0;
  int fails = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_all();
    m0b.accessType = MEM_ACCESS_NONE;
    m0b.addr       = 32'd0;
    m0b.dataOut    = 32'd0;
    m0b.memLen     = MEM_LEN_W;
    m1b.accessType = MEM_ACCESS_NONE;
    m1b.addr       = 32'd0;
    m1b.dataOut    = 32'd0;
    m1b.memLen     = MEM_LEN_W;
    sb.ready       = 1'b0;
    sb.abort       = 1'b0;
    sb.dataIn      = 32'd0;
  endtask

  task automatic do_reset();
    idle_all();
    res = 1'b1;
    step();
    step();
    res = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    logic [67:0] sv;
    do_reset();
    settle();
    outs = {grant, timeout, m0b.ready, m0b.abort,
            m1b.ready};
    tests++;
    if (outs !== 6'd0 || m1b.abort !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got %b/%b want 0",
               outs, m1b.abort);
    end
    sv = {sb.addr, sb.dataOut, sb.accessType, sb.memLen};
    tests++;
    if (sv !== {64'd0, MEM_ACCESS_NONE, MEM_LEN_W}) begin
      fails++;
      $display("FAIL reset_slave got %h want idle", sv);
    end
  endtask

  task automatic test_single_read();
    int nReady = 0;
    int m1r = 0;
    logic [31:0] got = 32'd0;
    do_reset();
    m0b.accessType = MEM_ACCESS_READ;
    m0b.addr       = 32'h8000_0000;
    m0b.memLen     = MEM_LEN_W;
    settle();
    tests++;
    if (grant !== 2'b00) begin
      fails++;
      $display("FAIL sr_pre_grant got %b want 00", grant);
    end
    step();
    settle();
    tests++;
    if (grant !== 2'b01) begin
      fails++;
      $display("FAIL sr_grant got %b want 01", grant);
    end
    tests++;
    if (sb.addr !== 32'h8000_0000 ||
        sb.accessType !== MEM_ACCESS_READ) begin
      fails++;
      $display("FAIL sr_saddr got %h/%0d want 80000000/1",
               sb.addr, sb.accessType);
    end
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) step();
      sb.ready  = (c == 3);
      sb.dataIn = (c == 3) ? 32'hCAFE_0001 : 32'h0;
      settle();
      if (m0b.ready) begin
        nReady++;
        got = m0b.dataIn;
      end
      if (m1b.ready) m1r++;
    end
    step();
    m0b.accessType = MEM_ACCESS_NONE;
    sb.ready = 1'b0;
    settle();
    tests++;
    if (grant !== 2'b00) begin
      fails++;
      $display("FAIL sr_post_grant got %b want 00", grant);
    end
    for (int c = 0; c < 3; c++) begin
      if (m0b.ready) nReady++;
      if (m1b.ready) m1r++;
      step();
      settle();
    end
    tests++;
    if (nReady != 1 || got !== 32'hCAFE_0001) begin
      fails++;
      $display("FAIL sr_ready got %0d/%h want 1/cafe0001",
               nReady, got);
    end
    tests++;
    if (m1r != 0) begin
      fails++;
      $display("FAIL sr_m1_ready got %0d want 0", m1r);
    end
  endtask

  task automatic test_tie_order();
    logic [1:0] exp [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    logic dOn;
    do_reset();
    m0b.accessType = MEM_ACCESS_READ;
    m0b.addr       = 32'h100;
    m0b.dataOut    = 32'h1111_1111;
    m1b.accessType = MEM_ACCESS_WRITE;
    m1b.addr       = 32'h200;
    m1b.dataOut    = 32'hDEAD_BEEF;
    settle();
    for (int k = 0; k < 5; k++) begin
      step();
      settle();
      sb.ready = (grant != 2'b00);
      settle();
      tests++;
      if (grant !== exp[k]) begin
        fails++;
        $display("FAIL tie_grant[%0d] got %b want %b",
                 k, grant, exp[k]);
      end
      dOn = (sb.dataOut === 32'hDEAD_BEEF);
      tests++;
      if (dOn !== (exp[k] == 2'b10)) begin
        fails++;
        $display("FAIL tie_wdata[%0d] got %h grant %b",
                 k, sb.dataOut, grant);
      end
    end
    step();
    idle_all();
    step();
  endtask

  task automatic test_ready_abort();
    do_reset();
    m1b.accessType = MEM_ACCESS_READ;
    m1b.addr       = 32'h40;
    step();
    settle();
    tests++;
    if (grant !== 2'b10) begin
      fails++;
      $display("FAIL ra_grant got %b want 10", grant);
    end
    sb.ready = 1'b1;
    sb.abort = 1'b1;
    settle();
    tests++;
    if ({m1b.ready, m1b.abort, m0b.ready, m0b.abort}
        !== 4'b0100) begin
      fails++;
      $display("FAIL ra_resp got %b want 0100",
               {m1b.ready, m1b.abort, m0b.ready, m0b.abort});
    end
    step();
    idle_all();
    settle();
    tests++;
    if (grant !== 2'b00) begin
      fails++;
      $display("FAIL ra_idle got %b want 00", grant);
    end
  endtask

  task automatic test_timeout();
    logic [1:0] want;
    do_reset();
    m0b.accessType = MEM_ACCESS_READ;
    m0b.addr       = 32'h80;
    step();
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) step();
      settle();
      want = (c == 4) ? 2'b11 : 2'b00;
      tests++;
      if ({timeout, m0b.abort} !== want) begin
        fails++;
        $display("FAIL to_cycle%0d got %b want %b",
                 c, {timeout, m0b.abort}, want);
      end
    end
    step();
    m0b.accessType = MEM_ACCESS_NONE;
    settle();
    tests++;
    if (grant !== 2'b00) begin
      fails++;
      $display("FAIL to_idle got %b want 00", grant);
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    m0b.accessType = MEM_ACCESS_READ;
    m1b.accessType = MEM_ACCESS_READ;
    m1b.addr       = 32'h300;
    step();
    settle();
    tests++;
    if (grant !== 2'b01) begin
      fails++;
      $display("FAIL wd_grant got %b want 01", grant);
    end
    step();
    m0b.accessType = MEM_ACCESS_NONE;
    settle();
    tests++;
    if ({m0b.ready, m0b.abort, timeout} !== 3'b000 ||
        sb.accessType !== MEM_ACCESS_NONE) begin
      fails++;
      $display("FAIL wd_cancel got %b/%0d want 000/0",
               {m0b.ready, m0b.abort, timeout},
               sb.accessType);
    end
    step();
    settle();
    tests++;
    if (grant !== 2'b00) begin
      fails++;
      $display("FAIL wd_idle got %b want 00", grant);
    end
    step();
    settle();
    tests++;
    if (grant !== 2'b10 || sb.addr !== 32'h300) begin
      fails++;
      $display("FAIL wd_m1 got %b/%h want 10/300",
               grant, sb.addr);
    end
    sb.ready = 1'b1;
    step();
    idle_all();
    step();
  endtask

  task automatic test_res_mid();
    int m1r = 0;
    do_reset();
    m1b.accessType = MEM_ACCESS_READ;
    step();
    settle();
    tests++;
    if (grant !== 2'b10) begin
      fails++;
      $display("FAIL rm_grant got %b want 10", grant);
    end
    step();
    res = 1'b1;
    m0b.accessType = MEM_ACCESS_READ;
    settle();
    step();
    res = 1'b0;
    settle();
    if (m1b.ready) m1r++;
    tests++;
    if (grant !== 2'b00 ||
        sb.accessType !== MEM_ACCESS_NONE || m1r != 0) begin
      fails++;
      $display("FAIL rm_idle got %b/%0d/%0d want 00/0/0",
               grant, sb.accessType, m1r);
    end
    step();
    settle();
    tests++;
    if (grant !== 2'b01) begin
      fails++;
      $display("FAIL rm_tie got %b want 01", grant);
    end
    idle_all();
    step();
  endtask

  task automatic test_random();
    localparam int N = 20;
    logic [31:0] ad [2];
    logic [31:0] dt [2];
    mem_access_t ty [2];
    mem_len_t    ln [2];
    bit act [2];
    int rem [2];
    int fin [2];
    logic [1:0] expG = 2'b00;
    bit mLast = 1'b1;
    int cyc = 0;
    int slvCnt = 0;
    int slvLat = 0;
    logic [67:0] wantS;
    logic [67:0] gotS;
    logic [4:0] wantR;
    logic [4:0] gotR;
    bit r0;
    bit r1;
    int o;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0;
      rem[i] = N;
      fin[i] = 0;
    end
    while ((rem[0] > 0 || rem[1] > 0) && cyc < 3000) begin
      step();
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!act[i] && rem[i] > 0 &&
            $urandom_range(0, 2) == 0) begin
          act[i] = 1;
          ad[i] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
          dt[i] = $urandom;
          ty[i] = $urandom_range(0, 1) ? MEM_ACCESS_WRITE
                                       : MEM_ACCESS_READ;
          ln[i] = mem_len_t'($urandom_range(0, 2));
        end
      end
      m0b.accessType = act[0] ? ty[0] : MEM_ACCESS_NONE;
      m0b.addr       = ad[0];
      m0b.dataOut    = dt[0];
      m0b.memLen     = ln[0];
      m1b.accessType = act[1] ? ty[1] : MEM_ACCESS_NONE;
      m1b.addr       = ad[1];
      m1b.dataOut    = dt[1];
      m1b.memLen     = ln[1];
      settle();
      tests++;
      if (grant !== expG) begin
        fails++;
        $display("FAIL rnd_grant c%0d got %b want %b",
                 cyc, grant, expG);
      end
      if (expG != 2'b00) begin
        if (slvCnt == 0) slvLat = $urandom_range(0, 2);
        sb.ready  = (slvCnt == slvLat);
        sb.abort  = sb.ready && ($urandom_range(0, 7) == 0);
        sb.dataIn = sb.ready ? (sb.addr ^ 32'hA5A5_0F0F)
                             : $urandom;
        slvCnt++;
      end else begin
        slvCnt    = 0;
        sb.ready  = 1'b0;
        sb.abort  = 1'b0;
        sb.dataIn = $urandom;
      end
      settle();
      o = (expG == 2'b01) ? 0 : 1;
      if (expG == 2'b00)
        wantS = {64'd0, MEM_ACCESS_NONE, MEM_LEN_W};
      else
        wantS = {ad[o], dt[o], ty[o], ln[o]};
      gotS = {sb.addr, sb.dataOut, sb.accessType, sb.memLen};
      tests++;
      if (gotS !== wantS) begin
        fails++;
        $display("FAIL rnd_fwd c%0d got %h want %h",
                 cyc, gotS, wantS);
      end
      r0 = (sb.ready && !sb.abort);
      wantR = 5'd0;
      if (expG == 2'b01) wantR[4:3] = {r0, sb.abort};
      if (expG == 2'b10) wantR[2:1] = {r0, sb.abort};
      gotR = {m0b.ready, m0b.abort, m1b.ready,
              m1b.abort, timeout};
      tests++;
      if (gotR !== wantR) begin
        fails++;
        $display("FAIL rnd_resp c%0d got %b want %b",
                 cyc, gotR, wantR);
      end
      if (r0 && expG != 2'b00) begin
        tests++;
        if (sb.dataIn !== (ad[o] ^ 32'hA5A5_0F0F) ||
            (o == 0 ? m0b.dataIn : m1b.dataIn)
              !== sb.dataIn) begin
          fails++;
          $display("FAIL rnd_rdata c%0d got %h want %h",
                   cyc, sb.dataIn, ad[o] ^ 32'hA5A5_0F0F);
        end
      end
      r1 = sb.ready || sb.abort;
      if (expG == 2'b00) begin
        if (act[0] && (!act[1] || mLast)) begin
          expG = 2'b01;
          mLast = 1'b0;
        end else if (act[1]) begin
          expG = 2'b10;
          mLast = 1'b1;
        end
      end else if (r1) begin
        act[o] = 0;
        rem[o]--;
        fin[o]++;
        expG = 2'b00;
      end
    end
    tests++;
    if (fin[0] != N || fin[1] != N) begin
      fails++;
      $display("FAIL rnd_done got %0d/%0d want %0d/%0d",
               fin[0], fin[1], N, N);
    end
    idle_all();
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit got expired want done");
    $fatal(1, "time limit");
  end

  initial begin
    res = 1'b1;
    idle_all();
    test_reset();
    test_single_read();
    test_tie_order();
    test_ready_abort();
    test_timeout();
    test_withdraw();
    test_res_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
